// File: rtl/pointwise_stage.sv
// Pointwise (1x1) convolution stage.
// Consumes an int8 activation stream pixel-major / channel-minor, MACs each
// beat against a preloaded weight bank, then per pixel adds bias, applies a
// Q31 multiplier with rounding shift, adds the output zero point, clamps and
// emits one int8 result. One output channel is produced per pass.
module pointwise_stage #(
    parameter int DATA_W  = 8,
    parameter int ACC_W   = 32,
    parameter int MAX_CIN = 1024,
    parameter int MAX_PIX = 12544,
    parameter int MUL_W   = 32,
    parameter int SHIFT_W = 6,
    localparam int CIN_W  = $clog2(MAX_CIN + 1),
    localparam int PIX_W  = $clog2(MAX_PIX + 1),
    localparam int ADDR_W = $clog2(MAX_CIN)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [CIN_W-1:0]   cfg_cin,
    input  logic [PIX_W-1:0]   cfg_num_pix,
    input  logic [DATA_W-1:0]  cfg_in_zp,
    input  logic [ACC_W-1:0]   pw_bias_acc,
    input  logic [MUL_W-1:0]   pw_mul,
    input  logic [SHIFT_W-1:0] pw_shift,
    input  logic [DATA_W-1:0]  pw_zp_out,
    input  logic [DATA_W-1:0]  pw_act_min,
    input  logic [DATA_W-1:0]  pw_act_max,
    input  logic               w_wr_en,
    input  logic [ADDR_W-1:0]  w_wr_addr,
    input  logic [DATA_W-1:0]  w_wr_data,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [DATA_W-1:0]  in_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [DATA_W-1:0]  out_data,
    output logic               busy,
    output logic               done
);

    localparam int MAC_W  = 2 * DATA_W + 1;
    localparam int PROD_W = ACC_W + MUL_W;

    localparam logic signed [PROD_W-1:0] HALF_Q31 = PROD_W'(64'h4000_0000);
    localparam logic signed [PROD_W-1:0] Q_MIN    = -(PROD_W'(1) << (DATA_W - 1));
    localparam logic signed [PROD_W-1:0] Q_MAX    = (PROD_W'(1) << (DATA_W - 1)) - PROD_W'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ACC,
        S_MUL,
        S_SHR,
        S_OUT,
        S_DONE
    } state_t;

    state_t state, state_n;

    // Per-pass configuration captured on start
    logic [CIN_W-1:0]          cin_q;
    logic [PIX_W-1:0]          npix_q;
    logic [DATA_W-1:0]         in_zp_q;
    logic signed [ACC_W-1:0]   bias_q;
    logic signed [MUL_W-1:0]   mul_q;
    logic [SHIFT_W-1:0]        shift_q;
    logic [DATA_W-1:0]         zp_out_q;
    logic [DATA_W-1:0]         act_min_q;
    logic [DATA_W-1:0]         act_max_q;

    // Pipeline state
    logic [CIN_W-1:0]          ch;
    logic [PIX_W-1:0]          pix;
    logic signed [ACC_W-1:0]   acc;
    logic signed [PROD_W-1:0]  prod;
    logic [DATA_W-1:0]         out_data_q;

    logic [DATA_W-1:0]         bank [MAX_CIN];
    logic signed [DATA_W-1:0]  w_rd;

    logic                      last_ch;
    logic                      last_pix;

    // MAC datapath: (x - zp_in) is DATA_W+1 wide, product is exact in MAC_W
    logic signed [DATA_W:0]    diff;
    logic signed [MAC_W-1:0]   diff_ext;
    logic signed [MAC_W-1:0]   w_ext;
    logic signed [MAC_W-1:0]   mac;
    logic signed [ACC_W-1:0]   mac_acc;

    // Requant datapath
    logic signed [ACC_W-1:0]   biased;
    logic signed [PROD_W-1:0]  biased_ext;
    logic signed [PROD_W-1:0]  mul_ext;
    logic signed [PROD_W-1:0]  prod_n;
    logic signed [PROD_W-1:0]  h;
    logic signed [PROD_W-1:0]  rnd_bias;
    logic signed [PROD_W-1:0]  r;
    logic signed [PROD_W-1:0]  zp_ext;
    logic signed [PROD_W-1:0]  min_ext;
    logic signed [PROD_W-1:0]  max_ext;
    logic signed [PROD_W-1:0]  v;
    logic signed [PROD_W-1:0]  v_cl;
    logic [DATA_W-1:0]         out_n;

    assign w_rd     = bank[ch[ADDR_W-1:0]];
    assign last_ch  = (ch == cin_q - CIN_W'(1));
    assign last_pix = (pix == npix_q - PIX_W'(1));

    assign diff     = {in_data[DATA_W-1], in_data} - {in_zp_q[DATA_W-1], in_zp_q};
    assign diff_ext = {{(MAC_W - DATA_W - 1){diff[DATA_W]}}, diff};
    assign w_ext    = {{(MAC_W - DATA_W){w_rd[DATA_W-1]}}, w_rd};
    assign mac      = diff_ext * w_ext;
    assign mac_acc  = {{(ACC_W - MAC_W){mac[MAC_W-1]}}, mac};

    assign biased     = acc + bias_q;
    assign biased_ext = {{MUL_W{biased[ACC_W-1]}}, biased};
    assign mul_ext    = {{ACC_W{mul_q[MUL_W-1]}}, mul_q};
    assign prod_n     = biased_ext * mul_ext;

    assign h        = (prod + HALF_Q31) >>> 31;
    assign rnd_bias = (shift_q == '0) ? '0 : (PROD_W'(1) << (shift_q - SHIFT_W'(1)));
    assign r        = (h + rnd_bias) >>> shift_q;
    assign zp_ext   = {{(PROD_W - DATA_W){zp_out_q[DATA_W-1]}}, zp_out_q};
    assign min_ext  = {{(PROD_W - DATA_W){act_min_q[DATA_W-1]}}, act_min_q};
    assign max_ext  = {{(PROD_W - DATA_W){act_max_q[DATA_W-1]}}, act_max_q};
    assign v        = r + zp_ext;

    // Activation clamp followed by int8 saturation of the requantised value
    always_comb begin
        // NOTE: every variable gets a default first so no path can infer a latch.
        v_cl  = v;
        out_n = '0;
        if (v < min_ext) begin
            v_cl = min_ext;
        end else if (v > max_ext) begin
            v_cl = max_ext;
        end
        if (v_cl < Q_MIN) begin
            out_n = Q_MIN[DATA_W-1:0];
        end else if (v_cl > Q_MAX) begin
            out_n = Q_MAX[DATA_W-1:0];
        end else begin
            out_n = v_cl[DATA_W-1:0];
        end
    end

    // State register
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next-state logic
    always_comb begin
        state_n = state;
        case (state)
            S_IDLE: begin
                if (start) begin
                    if (cfg_cin == '0 || cfg_num_pix == '0) begin
                        state_n = S_DONE;
                    end else begin
                        state_n = S_ACC;
                    end
                end
            end
            S_ACC: begin
                if (in_valid && last_ch) begin
                    state_n = S_MUL;
                end
            end
            S_MUL:  state_n = S_SHR;
            S_SHR:  state_n = S_OUT;
            S_OUT: begin
                if (out_ready) begin
                    state_n = last_pix ? S_DONE : S_ACC;
                end
            end
            S_DONE: state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    assign in_ready  = (state == S_ACC);
    assign out_valid = (state == S_OUT);
    assign busy      = (state != S_IDLE);
    assign done      = (state == S_DONE);
    assign out_data  = out_data_q;

    // Config capture, accumulation, requant pipeline and result register
    always_ff @(posedge clk) begin
        if (rst) begin
            cin_q      <= '0;
            npix_q     <= '0;
            in_zp_q    <= '0;
            bias_q     <= '0;
            mul_q      <= '0;
            shift_q    <= '0;
            zp_out_q   <= '0;
            act_min_q  <= '0;
            act_max_q  <= '0;
            ch         <= '0;
            pix        <= '0;
            acc        <= '0;
            prod       <= '0;
            out_data_q <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        cin_q     <= cfg_cin;
                        npix_q    <= cfg_num_pix;
                        in_zp_q   <= cfg_in_zp;
                        bias_q    <= pw_bias_acc;
                        mul_q     <= pw_mul;
                        shift_q   <= pw_shift;
                        zp_out_q  <= pw_zp_out;
                        act_min_q <= pw_act_min;
                        act_max_q <= pw_act_max;
                        ch        <= '0;
                        pix       <= '0;
                        acc       <= '0;
                    end
                end
                S_ACC: begin
                    if (in_valid) begin
                        acc <= acc + mac_acc;
                        ch  <= ch + CIN_W'(1);
                    end
                end
                S_MUL: prod <= prod_n;
                S_SHR: out_data_q <= out_n;
                S_OUT: begin
                    if (out_ready && !last_pix) begin
                        pix <= pix + PIX_W'(1);
                        acc <= '0;
                        ch  <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    // Weight bank: writable only while idle
    always_ff @(posedge clk) begin
        // NOTE: the bank is deliberately left out of reset so it maps onto plain RAM.
        if (state == S_IDLE && w_wr_en) begin
            bank[w_wr_addr] <= w_wr_data;
        end
    end

endmodule

// File: tb/tb_pointwise_stage.sv
// Directed bench for pointwise_stage: hand-computed vectors checked with
// immediate assertions, ending in a single summary line.
module tb_pointwise_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [10:0] cfg_cin;
    logic [13:0] cfg_num_pix;
    logic [7:0]  cfg_in_zp;
    logic [31:0] pw_bias_acc;
    logic [31:0] pw_mul;
    logic [5:0]  pw_shift;
    logic [7:0]  pw_zp_out;
    logic [7:0]  pw_act_min;
    logic [7:0]  pw_act_max;
    logic        w_wr_en;
    logic [9:0]  w_wr_addr;
    logic [7:0]  w_wr_data;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_data;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_data;
    logic        busy;
    logic        done;

    int n_checks = 0;
    int n_fail   = 0;
    int done_seen = 0;
    int done_base;

    pointwise_stage dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .cfg_cin     (cfg_cin),
        .cfg_num_pix (cfg_num_pix),
        .cfg_in_zp   (cfg_in_zp),
        .pw_bias_acc (pw_bias_acc),
        .pw_mul      (pw_mul),
        .pw_shift    (pw_shift),
        .pw_zp_out   (pw_zp_out),
        .pw_act_min  (pw_act_min),
        .pw_act_max  (pw_act_max),
        .w_wr_en     (w_wr_en),
        .w_wr_addr   (w_wr_addr),
        .w_wr_data   (w_wr_data),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .busy        (busy),
        .done        (done)
    );

    // 100 MHz clock
    always #5 clk = ~clk;

    // Count done pulses seen at clock edges
    always @(posedge clk) begin
        if (done === 1'b1) done_seen++;
    end

    // Hard stop in case the sequence itself stalls
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] sx(input logic [7:0] val);
        return {{24{val[7]}}, val};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, $signed(obs), $signed(exp));
        end
    endtask

    task automatic write_w(input int addr, input int data);
        w_wr_en   = 1'b1;
        w_wr_addr = 10'(addr);
        w_wr_data = 8'(data);
        tick();
        w_wr_en   = 1'b0;
    endtask

    task automatic configure(input int cin, input int npix, input int in_zp, input int bias,
                             input logic [31:0] mul, input int shift, input int zp_out,
                             input int amin, input int amax);
        cfg_cin     = 11'(cin);
        cfg_num_pix = 14'(npix);
        cfg_in_zp   = 8'(in_zp);
        pw_bias_acc = 32'(bias);
        pw_mul      = mul;
        pw_shift    = 6'(shift);
        pw_zp_out   = 8'(zp_out);
        pw_act_min  = 8'(amin);
        pw_act_max  = 8'(amax);
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic beat(input int d);
        in_valid = 1'b1;
        in_data  = 8'(d);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic beats(input int n, input int d);
        for (int i = 0; i < n; i++) beat(d);
    endtask

    task automatic wait_valid(input string tag);
        int waited = 0;
        while (out_valid !== 1'b1 && waited < 20) begin
            tick();
            waited++;
        end
        if (out_valid !== 1'b1) begin
            n_checks++;
            n_fail++;
            $error("FAIL %s: out_valid timeout observed 0 expected 1", tag);
        end
    endtask

    task automatic expect_out(input string tag, input int exp);
        wait_valid(tag);
        chk(tag, sx(out_data), 32'(exp));
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic expect_done(input string tag);
        chk({tag, "_done"}, 32'(done), 32'd1);
        tick();
        chk({tag, "_idle"}, 32'(busy), 32'd0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; w_wr_en = 1'b0; w_wr_addr = '0; w_wr_data = '0;
        in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        configure(0, 0, 0, 0, 32'd0, 0, 0, -128, 127);
        tick();
        tick();
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_out_data", sx(out_data), 32'd0);
        rst = 1'b0;
        tick();

        // Basic MAC: w={1,2,3,4}, x=1 -> acc 10, *0.5 -> 5; exact latency t+3
        write_w(0, 1); write_w(1, 2); write_w(2, 3); write_w(3, 4);
        configure(4, 1, 0, 0, 32'h4000_0000, 0, 0, -128, 127);
        do_start();
        chk("t1_busy", 32'(busy), 32'd1);
        chk("t1_in_ready", 32'(in_ready), 32'd1);
        // Config changes and a repeated start during the pass must be ignored
        cfg_cin = 11'd1;
        pw_mul  = 32'd0;
        start   = 1'b1;
        beats(4, 1);
        start   = 1'b0;
        chk("t1_lat1_valid", 32'(out_valid), 32'd0);
        chk("t1_lat1_ready", 32'(in_ready), 32'd0);
        tick();
        chk("t1_lat2_valid", 32'(out_valid), 32'd0);
        tick();
        chk("t1_lat3_valid", 32'(out_valid), 32'd1);
        chk("t1_out", sx(out_data), 32'd5);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        expect_done("t1");

        // Input zp -1, bias 6, zp_out 3: acc 20, +6=26, *0.5 -> 13, +3 -> 16
        configure(4, 1, -1, 6, 32'h4000_0000, 0, 3, -128, 127);
        do_start();
        beats(4, 1);
        expect_out("t1b_bias_zp", 16);
        expect_done("t1b");

        // 127*127*2 = 32258, mul 2^31-1, shift 8 -> 126; shift 0 -> clamp 127
        write_w(0, 127); write_w(1, 127);
        configure(2, 1, 0, 0, 32'h7FFF_FFFF, 8, 0, 0, 127);
        do_start();
        beats(2, 127);
        expect_out("t2_shift8", 126);
        expect_done("t2a");
        configure(2, 1, 0, 0, 32'h7FFF_FFFF, 0, 0, 0, 127);
        do_start();
        beats(2, 127);
        expect_out("t2_shift0_clamp", 127);
        expect_done("t2b");

        // Clamp window [-128,-20]: +40 -> -20, -200 -> -128
        write_w(0, 40);
        configure(1, 1, 0, 0, 32'h7FFF_FFFF, 0, 0, -128, -20);
        do_start();
        beat(1);
        expect_out("t3_clamp_hi", -20);
        expect_done("t3a");
        write_w(0, 2);
        do_start();
        beat(-100);
        expect_out("t3_clamp_lo", -128);
        expect_done("t3b");

        // Three pixels, backpressure on pixel 1; w={1,2,3} -> 3, 6, 9
        write_w(0, 1); write_w(1, 2); write_w(2, 3);
        configure(3, 3, 0, 0, 32'h4000_0000, 0, 0, -128, 127);
        done_base = done_seen;
        do_start();
        beats(3, 1);
        expect_out("t4_pix0", 3);
        chk("t4_no_done_mid", 32'(done), 32'd0);
        beats(3, 2);
        wait_valid("t4_pix1_wait");
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_data  = 8'd50;
            chk("t4_hold_data", sx(out_data), 32'd6);
            chk("t4_hold_valid", 32'(out_valid), 32'd1);
            chk("t4_hold_in_ready", 32'(in_ready), 32'd0);
            tick();
        end
        in_valid = 1'b0;
        expect_out("t4_pix1", 6);
        beats(3, 3);
        expect_out("t4_pix2", 9);
        expect_done("t4");
        chk("t4_done_count", 32'(done_seen - done_base), 32'd1);

        // Weight write during a pass is ignored; both passes use {1,2,3}
        configure(3, 1, 0, 0, 32'h4000_0000, 0, 0, -128, 127);
        do_start();
        w_wr_en = 1'b1; w_wr_addr = 10'd0; w_wr_data = 8'd100;
        beat(1);
        w_wr_en = 1'b0;
        beats(2, 1);
        expect_out("t5_pass_a", 3);
        expect_done("t5a");
        do_start();
        beats(3, 1);
        expect_out("t5_pass_b_old_w", 3);
        expect_done("t5b");

        // Zero channels: straight to done, never out_valid
        configure(0, 1, 0, 0, 32'h4000_0000, 0, 0, -128, 127);
        done_base = done_seen;
        do_start();
        for (int i = 0; i < 4; i++) begin
            chk("t6_no_out_valid", 32'(out_valid), 32'd0);
            tick();
        end
        chk("t6_done_count", 32'(done_seen - done_base), 32'd1);
        chk("t6_idle", 32'(busy), 32'd0);

        // Reset during ACC of pixel 2, then a clean single-pixel pass
        configure(3, 3, 0, 0, 32'h4000_0000, 0, 0, -128, 127);
        do_start();
        beats(3, 1);
        expect_out("t7_pix0", 3);
        beats(3, 2);
        expect_out("t7_pix1", 6);
        beat(3);
        rst = 1'b1;
        tick();
        chk("t7_rst_in_ready", 32'(in_ready), 32'd0);
        chk("t7_rst_out_valid", 32'(out_valid), 32'd0);
        chk("t7_rst_busy", 32'(busy), 32'd0);
        chk("t7_rst_done", 32'(done), 32'd0);
        chk("t7_rst_out_data", sx(out_data), 32'd0);
        rst = 1'b0;
        tick();
        configure(3, 1, 0, 0, 32'h4000_0000, 0, 0, -128, 127);
        do_start();
        beats(3, 1);
        expect_out("t7_restart_pix0", 3);
        expect_done("t7");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
